aes_mode_engine: RTL

- Parametrised streaming block-cipher engine for the HWPE accelerator datapath.
- Gathers DATA_W-bit stream words into BLOCK_W-bit blocks and drives an external cipher core through a load/done handshake, then serialises the results back onto the output stream.
- Generalises the single-mode, fixed-width engine with configurable word/block width, ECB/CBC/CTR chaining, block-count-driven runs, and key retention across jobs.

---
 rtl/aes_mode_engine_if.sv | 28 ++
 rtl/aes_mode_engine.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_mode_engine_if.sv
// Stream bundle for the AES mode engine: key input, plaintext input and
// result output, each with a valid/ready handshake.
interface aes_mode_engine_if #(
    parameter int DATA_W = 32
);
    logic                  key_valid;
    logic                  key_ready;
    logic [DATA_W-1:0]     key_data;
    logic                  a_valid;
    logic                  a_ready;
    logic [DATA_W-1:0]     a_data;
    logic                  d_valid;
    logic                  d_ready;
    logic [DATA_W-1:0]     d_data;
    logic [DATA_W/8-1:0]   d_strb;

    // Engine side: consumes key/plaintext, produces results.
    modport slave (
        input  key_valid, key_data, a_valid, a_data, d_ready,
        output key_ready, a_ready, d_valid, d_data, d_strb
    );

    // Producer/consumer side attached to the engine.
    modport master (
        output key_valid, key_data, a_valid, a_data, d_ready,
        input  key_ready, a_ready, d_valid, d_data, d_strb
    );
endinterface

// File: rtl/aes_mode_engine.sv
// Streaming block-cipher mode engine: gathers stream words into blocks,
// drives an external cipher core with ECB/CBC/CTR chaining and serialises
// the results. First word of every block is the most significant.
module aes_mode_engine #(
    parameter int DATA_W  = 32,
    parameter int BLOCK_W = 128,
    parameter int CNT_W   = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clear_i,
    input  logic               enable_i,
    input  logic               start_i,
    input  logic [1:0]         mode_i,
    input  logic               key_reload_i,
    input  logic [CNT_W-1:0]   len_i,
    input  logic [BLOCK_W-1:0] iv_i,
    aes_mode_engine_if.slave   bus,
    output logic               cph_ld_o,
    output logic [BLOCK_W-1:0] cph_key_o,
    output logic [BLOCK_W-1:0] cph_text_o,
    input  logic               cph_done_i,
    input  logic [BLOCK_W-1:0] cph_text_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [CNT_W-1:0]   blk_cnt_o
);

    localparam int N    = BLOCK_W / DATA_W;
    localparam int WC_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [WC_W-1:0] LAST_WORD = WC_W'(N - 1);

    localparam logic [1:0] MODE_ECB = 2'd0;
    localparam logic [1:0] MODE_CBC = 2'd1;
    localparam logic [1:0] MODE_CTR = 2'd2;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD_KEY = 3'd1;
    localparam logic [2:0] S_GATHER   = 3'd2;
    localparam logic [2:0] S_CIPHER   = 3'd3;
    localparam logic [2:0] S_WAIT     = 3'd4;
    localparam logic [2:0] S_EMIT     = 3'd5;

    logic [2:0]         state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   blk_cnt_q, blk_cnt_d;
    logic [WC_W-1:0]    word_cnt_q, word_cnt_d;
    logic [BLOCK_W-1:0] key_q, key_d;
    logic               key_loaded_q, key_loaded_d;
    logic [BLOCK_W-1:0] chain_q, chain_d;
    logic [BLOCK_W-1:0] pt_q, pt_d;
    logic [BLOCK_W-1:0] res_q, res_d;
    logic [BLOCK_W-1:0] cph_key_q, cph_key_d;
    logic [BLOCK_W-1:0] cph_text_q, cph_text_d;
    logic               done_q, done_d;

    // Next-state and datapath logic; clear_i overrides everything at the end.
    always_comb begin
        // NOTE: every _d starts as its _q so no path leaves a variable unassigned (no latches).
        state_d      = state_q;
        mode_d       = mode_q;
        len_d        = len_q;
        blk_cnt_d    = blk_cnt_q;
        word_cnt_d   = word_cnt_q;
        key_d        = key_q;
        key_loaded_d = key_loaded_q;
        chain_d      = chain_q;
        pt_d         = pt_q;
        res_d        = res_q;
        cph_key_d    = cph_key_q;
        cph_text_d   = cph_text_q;
        done_d       = done_q;

        if (enable_i) begin
            done_d = 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        mode_d     = (mode_i == 2'd3) ? MODE_ECB : mode_i;
                        len_d      = len_i;
                        chain_d    = iv_i;
                        blk_cnt_d  = '0;
                        word_cnt_d = '0;
                        if (len_i == '0) begin
                            done_d = 1'b1;
                        end else if (key_reload_i || !key_loaded_q) begin
                            state_d = S_LOAD_KEY;
                        end else begin
                            state_d = S_GATHER;
                        end
                    end
                end
                S_LOAD_KEY: begin
                    if (bus.key_valid) begin
                        key_d = (key_q << DATA_W) | BLOCK_W'(bus.key_data);
                        if (word_cnt_q == LAST_WORD) begin
                            word_cnt_d   = '0;
                            key_loaded_d = 1'b1;
                            state_d      = S_GATHER;
                        end else begin
                            word_cnt_d = word_cnt_q + WC_W'(1);
                        end
                    end
                end
                S_GATHER: begin
                    if (bus.a_valid) begin
                        pt_d = (pt_q << DATA_W) | BLOCK_W'(bus.a_data);
                        if (word_cnt_q == LAST_WORD) begin
                            word_cnt_d = '0;
                            state_d    = S_CIPHER;
                            cph_key_d  = key_q;
                            case (mode_q)
                                MODE_CBC: cph_text_d = pt_d ^ chain_q;
                                MODE_CTR: cph_text_d = chain_q;
                                default:  cph_text_d = pt_d;
                            endcase
                        end else begin
                            word_cnt_d = word_cnt_q + WC_W'(1);
                        end
                    end
                end
                S_CIPHER: begin
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (cph_done_i) begin
                        res_d   = (mode_q == MODE_CTR) ? (cph_text_i ^ pt_q) : cph_text_i;
                        state_d = S_EMIT;
                        if (mode_q == MODE_CBC) begin
                            chain_d = cph_text_i;
                        end else if (mode_q == MODE_CTR) begin
                            chain_d = chain_q + BLOCK_W'(1);
                        end
                    end
                end
                S_EMIT: begin
                    if (bus.d_ready) begin
                        res_d = res_q << DATA_W;
                        if (word_cnt_q == LAST_WORD) begin
                            word_cnt_d = '0;
                            blk_cnt_d  = blk_cnt_q + CNT_W'(1);
                            if (blk_cnt_d == len_q) begin
                                done_d  = 1'b1;
                                state_d = S_IDLE;
                            end else begin
                                state_d = S_GATHER;
                            end
                        end else begin
                            word_cnt_d = word_cnt_q + WC_W'(1);
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (clear_i) begin
            state_d      = S_IDLE;
            mode_d       = '0;
            len_d        = '0;
            blk_cnt_d    = '0;
            word_cnt_d   = '0;
            key_d        = '0;
            key_loaded_d = 1'b0;
            chain_d      = '0;
            pt_d         = '0;
            res_d        = '0;
            cph_key_d    = '0;
            cph_text_d   = '0;
            done_d       = 1'b0;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst_i) begin
            state_q      <= S_IDLE;
            mode_q       <= '0;
            len_q        <= '0;
            blk_cnt_q    <= '0;
            word_cnt_q   <= '0;
            key_q        <= '0;
            key_loaded_q <= 1'b0;
            chain_q      <= '0;
            pt_q         <= '0;
            res_q        <= '0;
            cph_key_q    <= '0;
            cph_text_q   <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            len_q        <= len_d;
            blk_cnt_q    <= blk_cnt_d;
            word_cnt_q   <= word_cnt_d;
            key_q        <= key_d;
            key_loaded_q <= key_loaded_d;
            chain_q      <= chain_d;
            pt_q         <= pt_d;
            res_q        <= res_d;
            cph_key_q    <= cph_key_d;
            cph_text_q   <= cph_text_d;
            done_q       <= done_d;
        end
    end

    // Moore handshake outputs, gated by the global enable.
    assign bus.key_ready = enable_i && (state_q == S_LOAD_KEY);
    assign bus.a_ready   = enable_i && (state_q == S_GATHER);
    assign bus.d_valid   = enable_i && (state_q == S_EMIT);
    assign bus.d_data    = res_q[BLOCK_W-1 -: DATA_W];
    assign bus.d_strb    = '1;
    assign cph_ld_o      = enable_i && (state_q == S_CIPHER);
    assign cph_key_o     = cph_key_q;
    assign cph_text_o    = cph_text_q;
    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = done_q;
    assign blk_cnt_o     = blk_cnt_q;

endmodule
